mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width in bits; legal values 8..64.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU in cycles; legal values >= 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU in cycles; legal values >= 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 A  input  WIDTH  operand 1 (multiplicand / dividend / MTHI-MTLO source).
REQ-007 B  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 MDUop  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-009 start  input  1  issue strobe; A, B and MDUop are sampled when start=1 at a rising edge.
REQ-010 busy  output  1  high while a multiply or divide is in flight.
REQ-011 HI  output  WIDTH  HI register, driven directly from the register.
REQ-012 LO  output  WIDTH  LO register, driven directly from the register.

Function
REQ-013 FSM: two states, IDLE and BUSY; the counter is a register wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-014 IDLE, start=1, MDUop in {MULT, MULTU}: latch the 2*WIDTH product, load counter with MULT_CYCLES, go to BUSY.
REQ-015 IDLE, start=1, MDUop in {DIV, DIVU}: latch quotient and remainder, load counter with DIV_CYCLES, go to BUSY.
REQ-016 busy = (state == BUSY); it rises at the edge that accepts the start and stays high for exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES.
REQ-017 BUSY: decrement the counter each cycle; at the edge where the counter reaches 0, write HI/LO and return to IDLE, with busy and HI/LO changing at the same edge.
REQ-018 MULT: signed WIDTH x WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-019 MULTU: unsigned product, with the same HI/LO split as MULT.
REQ-020 DIV: signed division; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-021 DIVU: unsigned division; LO = quotient, HI = remainder.
REQ-022 Divide by zero (B == 0, DIV or DIVU): full DIV_CYCLES busy period; HI and LO are left unchanged at completion.
REQ-023 DIV with A = most-negative value and B = -1: LO = most-negative value, HI = 0; no other effect.
REQ-024 MTHI in IDLE with start=1: HI <= A at that edge; busy stays 0; LO unchanged.
REQ-025 MTLO in IDLE with start=1: LO <= A at that edge; busy stays 0; HI unchanged.
REQ-026 Any start while in BUSY, including MTHI/MTLO, is ignored; the in-flight operation and HI/LO are unaffected.
REQ-027 start=1 with MDUop of 000 or 111: no state change.
REQ-028 A start accepted at the completion edge is not possible: at that edge the state is still BUSY, so the start is ignored; a new start is accepted from the following cycle.
REQ-029 When not writing, HI and LO hold their values indefinitely.

Reset
REQ-030 reset=1 at a rising edge: state <= IDLE, counter <= 0, busy <= 0, HI <= 0, LO <= 0; this takes priority over start and over completion.
REQ-031 reset during BUSY aborts the operation; its result is never written to HI/LO.
REQ-032 Power-up register values are 0, the same as the reset values.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-033 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; then MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-035 HI=0x12345678 preloaded by MTHI, then DIVU A=5, B=0 -> busy high 10 cycles, HI=0x12345678 and LO unchanged afterwards; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 MULT issued, then MTLO A=0xDEADBEEF with start=1 at busy cycle 2 -> ignored, LO = product low word at completion; the same MTLO one cycle after busy falls -> LO=0xDEADBEEF, busy stays 0.
REQ-037 DIV issued, reset=1 at busy cycle 3 -> next edge busy=0, HI=0, LO=0, and no later write occurs.
REQ-038 Back-to-back MULT: the second start is held high through the completion edge -> that edge ignores it; it is accepted on the next edge, and total busy time is 5 + 5 cycles with one idle cycle between.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDUop,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int W2   = 2 * WIDTH;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic            res_wr;

    logic is_mul;
    logic is_div;
    logic done;

    assign is_mul = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
    assign is_div = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
    assign done   = (state == BUSY) && (cnt == CW'(1));
    assign busy   = (state == BUSY);

    // Products are formed at full 2*WIDTH precision from sign/zero-extended operands
    logic [W2-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [W2-1:0] prod_s, prod_u;

    assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    assign a_zx   = {{WIDTH{1'b0}}, A};
    assign b_zx   = {{WIDTH{1'b0}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide works on magnitudes; the most-negative dividend's magnitude
    // is still exact as an unsigned value, so MIN / -1 wraps back to MIN.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, s_den, u_den;
    logic [WIDTH-1:0] s_q, s_r, q_s, r_s, u_q, u_r;

    assign a_neg = A[WIDTH-1];
    assign b_neg = B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;
    assign s_den = (B == '0) ? WIDTH'(1) : b_mag;
    assign u_den = (B == '0) ? WIDTH'(1) : B;
    assign s_q   = a_mag / s_den;
    assign s_r   = a_mag % s_den;
    assign q_s   = (a_neg ^ b_neg) ? -s_q : s_q;
    assign r_s   = a_neg ? -s_r : s_r;
    assign u_q   = A / u_den;
    assign u_r   = A % u_den;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (is_mul || is_div)) state_next = BUSY;
            BUSY: if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            HI     <= '0;
            LO     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (MDUop)
                            OP_MULT: begin
                                res_hi <= prod_s[W2-1:WIDTH];
                                res_lo <= prod_s[WIDTH-1:0];
                                res_wr <= 1'b1;
                                cnt    <= CW'(MULT_CYCLES);
                            end
                            OP_MULTU: begin
                                res_hi <= prod_u[W2-1:WIDTH];
                                res_lo <= prod_u[WIDTH-1:0];
                                res_wr <= 1'b1;
                                cnt    <= CW'(MULT_CYCLES);
                            end
                            OP_DIV: begin
                                res_hi <= r_s;
                                res_lo <= q_s;
                                res_wr <= (B != '0);
                                cnt    <= CW'(DIV_CYCLES);
                            end
                            OP_DIVU: begin
                                res_hi <= u_r;
                                res_lo <= u_q;
                                res_wr <= (B != '0);
                                cnt    <= CW'(DIV_CYCLES);
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (done && res_wr) begin
                        HI <= res_hi;
                        LO <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
